uart_imem_loader: RTL and testbench

Writer side of the instruction-memory interface: receives a program over UART and writes 32-bit words into instruction memory, which the fetch stage only ever reads. Holds the CPU pipeline in reset while loading and releases it on completion. Sits beside the CPU top, driving the instruction-memory write port and gating the CPU reset.

---
 rtl/uart_imem_loader_pkg.sv | 20 ++
 rtl/uart_imem_loader_if.sv | 11 +
 rtl/uart_imem_loader_uart_rx_byte.sv | 97 +++++++++
 rtl/uart_imem_loader.sv | 155 +++++++++++++++
 tb/tb_uart_imem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared constants for the UART instruction-memory loader: main and RX state
// encodings plus the UART frame shape.
package uart_imem_loader_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CNT_LO = 3'd1;
   localparam logic [2:0] CNT_HI = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] ERR    = 3'd5;

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_START = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;
   localparam logic [1:0] R_STOP  = 2'd3;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port: the loader is the master, the memory the slave.
interface uart_imem_loader_if #(
   parameter int ADDR_W = 14
);
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;

   modport master (output we, addr, wdata);
   modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/uart_imem_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling down-counter,
// one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
   import uart_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);
   localparam int            TW      = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL_LD = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LD = TW'(CLKS_PER_BIT / 2 - 1);

   if (CLKS_PER_BIT < 4 || UART_STOP_BITS != 1) begin : g_bad_cfg
      $error("uart_rx_byte: unsupported configuration");
   end

   logic          sync1_q, sync2_q, prev_q;
   logic [1:0]    rstate_q, rstate_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          valid_q, valid_d, ferr_q, ferr_d;
   logic          tick;

   assign tick = (timer_q == '0);

   always_comb begin
      rstate_d  = rstate_q;
      timer_d   = tick ? timer_q : timer_q - 1'b1;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (rstate_q)
         R_IDLE: if (prev_q && !sync2_q) begin
            rstate_d = R_START;
            timer_d  = HALF_LD;
         end
         R_START: if (tick) begin
            if (sync2_q) begin
               rstate_d = R_IDLE;
            end else begin
               rstate_d  = R_DATA;
               timer_d   = FULL_LD;
               bit_idx_d = '0;
            end
         end
         R_DATA: if (tick) begin
            shreg_d   = {sync2_q, shreg_q[7:1]};
            timer_d   = FULL_LD;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) rstate_d = R_STOP;
         end
         default: if (tick) begin
            valid_d  = sync2_q;
            ferr_d   = !sync2_q;
            rstate_d = R_IDLE;
         end
      endcase
   end

   // Sync flops reset high so reset release never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         rstate_q  <= R_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync1_q   <= uart_rx;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         rstate_q  <= rstate_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign byte_valid = valid_q;
   assign rx_byte    = shreg_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a length-prefixed program from UART into instruction memory while
// holding the CPU in reset; releases the CPU only after a complete load.
module uart_imem_loader
   import uart_imem_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 14,
   parameter int MAX_WORDS    = 16384
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               uart_rx,
   uart_imem_loader_if.master imem,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   logic        byte_valid, frame_err;
   logic [7:0]  rx_byte;
   logic        start_s1_q, start_s2_q, start_prev_q, start_edge;
   logic [2:0]  state_q, state_d;
   logic [15:0] count_q, count_d, n_rx;
   logic [16:0] word_cnt_q, word_cnt_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_q, word_d, wdata_q, wdata_d;
   logic        we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .byte_valid (byte_valid),
      .rx_byte    (rx_byte),
      .frame_err  (frame_err)
   );

   assign start_edge = start_s2_q && !start_prev_q;
   assign n_rx       = {rx_byte, count_q[7:0]};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;
      case (state_q)
         CNT_LO: if (byte_valid) begin
            count_d[7:0] = rx_byte;
            state_d      = CNT_HI;
         end
         CNT_HI: if (byte_valid) begin
            count_d[15:8] = rx_byte;
            if (n_rx == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
               hold_d  = 1'b0;
            end else if ({1'b0, n_rx} > MAX_N) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else begin
               state_d    = DATA;
               word_cnt_d = '0;
               byte_idx_d = '0;
            end
         end
         DATA: begin
            if (byte_valid) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  wdata_d = {rx_byte, word_q[23:0]};
                  addr_d  = ADDR_W'(word_cnt_q);
               end
            end
            // Address holds at the last written word; only the counter advances.
            if (we_q) begin
               word_cnt_d = word_cnt_q + 17'd1;
               if (word_cnt_d == {1'b0, count_q}) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end
            end
         end
         default: if (start_edge) begin
            state_d = CNT_LO;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            addr_d  = '0;
         end
      endcase
      if (frame_err && (state_q == CNT_LO || state_q == CNT_HI || state_q == DATA)) begin
         state_d = ERR;
         err_d   = 1'b1;
         hold_d  = 1'b1;
         we_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_s1_q   <= 1'b0;
         start_s2_q   <= 1'b0;
         start_prev_q <= 1'b0;
         state_q      <= IDLE;
         count_q      <= '0;
         word_cnt_q   <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         hold_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         start_s1_q   <= start;
         start_s2_q   <= start_s1_q;
         start_prev_q <= start_s2_q;
         state_q      <= state_d;
         count_q      <= count_d;
         word_cnt_q   <= word_cnt_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         hold_q       <= hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign imem.we    = we_q;
   assign imem.addr  = addr_q;
   assign imem.wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign busy       = (state_q == CNT_LO) || (state_q == CNT_HI) || (state_q == DATA);
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a fast UART (16 clk per bit).
module tb_uart_imem_loader;
   localparam int CPB    = 16;
   localparam int ADDR_W = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic uart_rx = 1'b1;
   logic cpu_hold, busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int done_rise_cyc = 0;
   logic done_prev = 1'b0;
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   logic              wr_hold[$];

   uart_imem_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

   uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .MAX_WORDS(16384)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .uart_rx  (uart_rx),
      .imem     (imem_bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (imem_bus.we === 1'b1) begin
         wr_addr.push_back(imem_bus.addr);
         wr_data.push_back(imem_bus.wdata);
         wr_hold.push_back(cpu_hold);
         last_we_cyc = cyc;
      end
      if (done === 1'b1 && done_prev === 1'b0) done_rise_cyc = cyc;
      done_prev = done;
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_hold.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_end(output logic timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (done === 1'b1 || err === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({imem_bus.we, imem_bus.addr, imem_bus.wdata, cpu_hold, busy, done, err} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b, want all 0",
                  imem_bus.we, imem_bus.addr, imem_bus.wdata, cpu_hold, busy, done, err);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_idle_rx();
      clear_log();
      send_byte(8'h55, 1'b1);
      send_byte(8'hA3, 1'b1);
      n_cmp++;
      if (wr_addr.size() != 0) begin
         n_bad++;
         $display("FAIL idle_rx_writes: got %0d writes, want 0", wr_addr.size());
      end
      n_cmp++;
      if ({cpu_hold, busy, done} !== 3'b000) begin
         n_bad++;
         $display("FAIL idle_rx_state: got hold/busy/done=%b%b%b, want 000", cpu_hold, busy, done);
      end
   endtask

   task automatic test_normal_load();
      logic to;
      clear_log();
      pulse_start();
      n_cmp++;
      if ({cpu_hold, busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL load_hold_after_start: got hold/busy=%b%b, want 11", cpu_hold, busy);
      end
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h12345678);
      send_word(32'hDEADBEEF);
      wait_end(to);
      n_cmp++;
      if (to) begin
         n_bad++;
         $display("FAIL load_timeout: got no done/err in 400 cycles, want done");
      end
      n_cmp++;
      if (wr_addr.size() != 2) begin
         n_bad++;
         $display("FAIL load_write_count: got %0d, want 2", wr_addr.size());
      end else begin
         n_cmp++;
         if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL load_word0: got addr=%0d data=%h, want addr=0 data=12345678", wr_addr[0], wr_data[0]);
         end
         n_cmp++;
         if (wr_addr[1] !== 14'd1 || wr_data[1] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL load_word1: got addr=%0d data=%h, want addr=1 data=deadbeef", wr_addr[1], wr_data[1]);
         end
         n_cmp++;
         if (wr_hold[0] !== 1'b1 || wr_hold[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL load_hold_during_write: got %b%b, want 11", wr_hold[0], wr_hold[1]);
         end
      end
      n_cmp++;
      if ({done, err, cpu_hold, busy} !== 4'b1000) begin
         n_bad++;
         $display("FAIL load_final_flags: got done/err/hold/busy=%b%b%b%b, want 1000", done, err, cpu_hold, busy);
      end
      n_cmp++;
      if (imem_bus.addr !== 14'd1) begin
         n_bad++;
         $display("FAIL load_final_addr: got %0d, want 1", imem_bus.addr);
      end
      n_cmp++;
      if (done_rise_cyc - last_we_cyc != 1) begin
         n_bad++;
         $display("FAIL load_done_latency: got %0d cycles, want 1", done_rise_cyc - last_we_cyc);
      end
   endtask

   task automatic test_zero_count();
      logic to;
      clear_log();
      pulse_start();
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_done_cleared: got %b, want 0", done);
      end
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      wait_end(to);
      n_cmp++;
      if (to || {done, err, cpu_hold} !== 3'b100 || wr_addr.size() != 0) begin
         n_bad++;
         $display("FAIL zero_count: got timeout=%b done/err/hold=%b%b%b writes=%0d, want 0 100 0",
                  to, done, err, cpu_hold, wr_addr.size());
      end
   endtask

   task automatic test_oversize();
      logic to;
      clear_log();
      pulse_start();
      send_byte(8'h01, 1'b1);
      send_byte(8'h40, 1'b1);
      wait_end(to);
      n_cmp++;
      if (to || {done, err, cpu_hold, busy} !== 4'b0110 || wr_addr.size() != 0) begin
         n_bad++;
         $display("FAIL oversize: got timeout=%b done/err/hold/busy=%b%b%b%b writes=%0d, want 0 0110 0",
                  to, done, err, cpu_hold, busy, wr_addr.size());
      end
   endtask

   task automatic test_frame_err();
      logic to;
      clear_log();
      pulse_start();
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b1);
      wait_end(to);
      n_cmp++;
      if (to || {done, err, cpu_hold, busy} !== 4'b0110 || wr_addr.size() != 0) begin
         n_bad++;
         $display("FAIL frame_err: got timeout=%b done/err/hold/busy=%b%b%b%b writes=%0d, want 0 0110 0",
                  to, done, err, cpu_hold, busy, wr_addr.size());
      end
      pulse_start();
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL frame_err_cleared: got %b, want 0", err);
      end
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'hDDCCBBAA);
      wait_end(to);
      n_cmp++;
      if (to || done !== 1'b1 || wr_addr.size() != 1) begin
         n_bad++;
         $display("FAIL frame_err_recover: got timeout=%b done=%b writes=%0d, want 0 1 1", to, done, wr_addr.size());
      end else begin
         n_cmp++;
         if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'hDDCCBBAA) begin
            n_bad++;
            $display("FAIL frame_err_recover_word: got addr=%0d data=%h, want 0 ddccbbaa", wr_addr[0], wr_data[0]);
         end
      end
   endtask

   task automatic test_glitch_ignored_start();
      logic to;
      clear_log();
      pulse_start();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      send_byte(8'h0D, 1'b1);
      send_byte(8'hF0, 1'b1);
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
         n_bad++;
         $display("FAIL ignored_start_busy: got busy/hold=%b%b, want 11", busy, cpu_hold);
      end
      send_byte(8'hAD, 1'b1);
      send_byte(8'hBA, 1'b1);
      wait_end(to);
      n_cmp++;
      if (to || done !== 1'b1 || wr_addr.size() != 1) begin
         n_bad++;
         $display("FAIL glitch_load: got timeout=%b done=%b writes=%0d, want 0 1 1", to, done, wr_addr.size());
      end else begin
         n_cmp++;
         if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'hBAADF00D) begin
            n_bad++;
            $display("FAIL glitch_word: got addr=%0d data=%h, want 0 baadf00d", wr_addr[0], wr_data[0]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic to;
      clear_log();
      pulse_start();
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h44332211);
      n_cmp++;
      if (wr_addr.size() != 1 || imem_bus.wdata !== 32'h44332211) begin
         n_bad++;
         $display("FAIL mid_load_first_word: got writes=%0d wdata=%h, want 1 44332211", wr_addr.size(), imem_bus.wdata);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({imem_bus.we, imem_bus.addr, imem_bus.wdata, cpu_hold, busy, done, err} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: got we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b, want all 0",
                  imem_bus.we, imem_bus.addr, imem_bus.wdata, cpu_hold, busy, done, err);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      clear_log();
      pulse_start();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'hCAFEF00D);
      wait_end(to);
      n_cmp++;
      if (to || done !== 1'b1 || wr_addr.size() != 1) begin
         n_bad++;
         $display("FAIL reload: got timeout=%b done=%b writes=%0d, want 0 1 1", to, done, wr_addr.size());
      end else begin
         n_cmp++;
         if (wr_addr[0] !== 14'd0 || wr_data[0] !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL reload_word: got addr=%0d data=%h, want 0 cafef00d", wr_addr[0], wr_data[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_rx();
      test_normal_load();
      test_zero_count();
      test_oversize();
      test_frame_err();
      test_glitch_ignored_start();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
